// File: rtl/reg_write_buffer_if.sv
// Bus bundle for the posted-write buffer: writeback push side, register file
// write side, status and the two bypass read ports.
interface reg_write_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ADDR_W = 5;

  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic              hold;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;

  // Writeback stage / decode stage side
  modport master (
    output push, push_addr, push_data, hold, rd1_addr, rd2_addr,
    input  full, count, overflow, wb_write, wb_addr, wb_data,
           hit1, hit2, fwd1, fwd2
  );

  // Buffer side
  modport slave (
    input  push, push_addr, push_data, hold, rd1_addr, rd2_addr,
    output full, count, overflow, wb_write, wb_addr, wb_data,
           hit1, hit2, fwd1, fwd2
  );
endinterface

// File: rtl/reg_write_buffer.sv
// Posted-write buffer in front of the register file write port. Pushes are
// queued in a small circular FIFO and drained one per cycle into a registered
// write port; two combinational bypass ports return the youngest pending value.
module reg_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  reg_write_buffer_if.slave io_wbuf
);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ADDR_W = 5;

  // FIFO storage, valid entries are head..head+count-1
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_wb_write;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  logic              w_full;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_pop;
  logic [DATA_W:0]   w_look1;
  logic [DATA_W:0]   w_look2;

  // Full is judged on the pre-edge count, so a same-edge pop never frees a slot
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_push_req = io_wbuf.push && (io_wbuf.push_addr != '0);
  assign w_push_ok  = w_push_req && !w_full;
  assign w_drop     = w_push_req && w_full;
  assign w_pop      = (r_count != '0) && !io_wbuf.hold;

  // Entry storage; contents are masked by count so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_reset) begin
      r_mem_addr[r_tail] <= io_wbuf.push_addr;
      r_mem_data[r_tail] <= io_wbuf.push_data;
    end
  end

  // Head/tail pointers, wrap naturally at the power-of-two depth
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)     r_head <= r_head + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Register file write port: one-cycle strobe per drained entry, data held otherwise
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wb_write <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (w_pop) begin
      r_wb_write <= 1'b1;
      r_wb_addr  <= r_mem_addr[r_head];
      r_wb_data  <= r_mem_data[r_head];
    end else begin
      r_wb_write <= 1'b0;
    end
  end

  // Scan oldest to youngest (WB register, then head..tail-1); last match wins
  function automatic logic [DATA_W:0] f_lookup(input logic [ADDR_W-1:0] addr);
    logic              hit;
    logic [DATA_W-1:0] val;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    val = '0;
    idx = '0;
    if (addr != '0) begin
      if (r_wb_write && (r_wb_addr == addr)) begin
        hit = 1'b1;
        val = r_wb_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = r_head + PTR_W'(i);
        if ((CNT_W'(i) < r_count) && (r_mem_addr[idx] == addr)) begin
          hit = 1'b1;
          val = r_mem_data[idx];
        end
      end
    end
    return {hit, val};
  endfunction

  // Bypass lookup for both decode read ports
  always_comb begin
    w_look1 = '0;
    w_look2 = '0;
    w_look1 = f_lookup(io_wbuf.rd1_addr);
    w_look2 = f_lookup(io_wbuf.rd2_addr);
  end

  assign io_wbuf.full     = w_full;
  assign io_wbuf.count    = r_count;
  assign io_wbuf.overflow = r_overflow;
  assign io_wbuf.wb_write = r_wb_write;
  assign io_wbuf.wb_addr  = r_wb_addr;
  assign io_wbuf.wb_data  = r_wb_data;
  assign io_wbuf.hit1     = w_look1[DATA_W];
  assign io_wbuf.fwd1     = w_look1[DATA_W-1:0];
  assign io_wbuf.hit2     = w_look2[DATA_W];
  assign io_wbuf.fwd2     = w_look2[DATA_W-1:0];

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench for reg_write_buffer: directed vector table, an ordered
// streaming sequence, and randomized traffic against a queue-based model.
module tb_reg_write_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst;

  reg_write_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bif ();

  reg_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_wbuf (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending writes as a queue, plus the write-port register
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        q[$];
  logic        m_wbw = 1'b0;
  logic [4:0]  m_wba = '0;
  logic [31:0] m_wbd = '0;
  logic        m_ovf = 1'b0;

  typedef struct {
    logic        rst, push;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        hold;
    logic [4:0]  r1, r2;
    logic [2:0]  cnt;
    logic        full, ovf, wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        h1;
    logic [31:0] f1;
    logic        h2;
    logic [31:0] f2;
  } vec_t;

  function automatic vec_t mk(int r, int p, int pa, logic [31:0] pd, int h, int r1, int r2,
                              int cnt, int full, int ovf, int wbw, int wba, logic [31:0] wbd,
                              int h1, logic [31:0] f1, int h2, logic [31:0] f2);
    vec_t v;
    v.rst = 1'(r);   v.push = 1'(p);  v.pa = 5'(pa); v.pd = pd; v.hold = 1'(h);
    v.r1 = 5'(r1);   v.r2 = 5'(r2);   v.cnt = 3'(cnt); v.full = 1'(full);
    v.ovf = 1'(ovf); v.wbw = 1'(wbw); v.wba = 5'(wba); v.wbd = wbd;
    v.h1 = 1'(h1);   v.f1 = f1;       v.h2 = 1'(h2);   v.f2 = f2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest-first search of the model's pending writes
  task automatic m_lookup(input logic [4:0] addr, output logic hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (addr != 5'd0) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!hit && q[k].a == addr) begin
          hit = 1'b1;
          val = q[k].d;
        end
      end
      if (!hit && m_wbw && m_wba == addr) begin
        hit = 1'b1;
        val = m_wbd;
      end
    end
  endtask

  task automatic model_edge(input logic r, input logic p, input logic [4:0] pa,
                            input logic [31:0] pd, input logic h);
    bit   was_full;
    ent_t e;
    was_full = (q.size() == DEPTH);
    if (r) begin
      q.delete();
      m_wbw = 1'b0; m_wba = '0; m_wbd = '0; m_ovf = 1'b0;
    end else begin
      if (q.size() != 0 && !h) begin
        e = q.pop_front();
        m_wbw = 1'b1; m_wba = e.a; m_wbd = e.d;
      end else begin
        m_wbw = 1'b0;
      end
      if (p && pa != 5'd0) begin
        if (was_full) m_ovf = 1'b1;
        else begin
          e.a = pa; e.d = pd;
          q.push_back(e);
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle
  task automatic apply(input logic r, input logic p, input logic [4:0] pa,
                       input logic [31:0] pd, input logic h,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst = r;
    bif.push = p; bif.push_addr = pa; bif.push_data = pd; bif.hold = h;
    bif.rd1_addr = r1; bif.rd2_addr = r2;
    @(posedge clk);
    model_edge(r, p, pa, pd, h);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic        h1, h2;
    logic [31:0] f1, f2;
    m_lookup(bif.rd1_addr, h1, f1);
    m_lookup(bif.rd2_addr, h2, f2);
    chk({tag, ".count"},    32'(bif.count),    32'(q.size()));
    chk({tag, ".full"},     32'(bif.full),     32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(bif.overflow), 32'(m_ovf));
    chk({tag, ".wb_write"}, 32'(bif.wb_write), 32'(m_wbw));
    chk({tag, ".wb_addr"},  32'(bif.wb_addr),  32'(m_wba));
    chk({tag, ".wb_data"},  bif.wb_data,       m_wbd);
    chk({tag, ".hit1"},     32'(bif.hit1),     32'(h1));
    chk({tag, ".fwd1"},     bif.fwd1,          f1);
    chk({tag, ".hit2"},     32'(bif.hit2),     32'(h2));
    chk({tag, ".fwd2"},     bif.fwd2,          f2);
  endtask

  vec_t vt[23];
  int   issued;
  int   next_expected;

  initial begin
    rst = 1'b1;
    bif.push = 1'b0; bif.push_addr = '0; bif.push_data = '0; bif.hold = 1'b0;
    bif.rd1_addr = '0; bif.rd2_addr = '0;

    //           rst p  pa  pd            h  r1 r2  cnt f  o  w  wba wbd           h1 f1            h2 f2
    vt[0]  = mk(1, 0, 0, 32'h0,         0, 0, 0,  0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vt[1]  = mk(0, 1, 5, 32'hDEADBEEF,  0, 5, 0,  1, 0, 0, 0, 0, 32'h0,         1, 32'hDEADBEEF,  0, 32'h0);
    vt[2]  = mk(0, 0, 0, 32'h0,         0, 5, 0,  0, 0, 0, 1, 5, 32'hDEADBEEF,  1, 32'hDEADBEEF,  0, 32'h0);
    vt[3]  = mk(0, 0, 0, 32'h0,         0, 5, 0,  0, 0, 0, 0, 5, 32'hDEADBEEF,  0, 32'h0,         0, 32'h0);
    vt[4]  = mk(0, 1, 1, 32'h1,         1, 1, 0,  1, 0, 0, 0, 5, 32'hDEADBEEF,  1, 32'h1,         0, 32'h0);
    vt[5]  = mk(0, 1, 2, 32'h2,         1, 1, 0,  2, 0, 0, 0, 5, 32'hDEADBEEF,  1, 32'h1,         0, 32'h0);
    vt[6]  = mk(0, 1, 3, 32'h3,         1, 3, 0,  3, 0, 0, 0, 5, 32'hDEADBEEF,  1, 32'h3,         0, 32'h0);
    vt[7]  = mk(0, 1, 4, 32'h4,         1, 4, 0,  4, 1, 0, 0, 5, 32'hDEADBEEF,  1, 32'h4,         0, 32'h0);
    vt[8]  = mk(0, 1, 6, 32'h66,        1, 6, 4,  4, 1, 1, 0, 5, 32'hDEADBEEF,  0, 32'h0,         1, 32'h4);
    vt[9]  = mk(0, 0, 0, 32'h0,         0, 4, 1,  3, 0, 1, 1, 1, 32'h1,         1, 32'h4,         1, 32'h1);
    vt[10] = mk(0, 0, 0, 32'h0,         0, 4, 1,  2, 0, 1, 1, 2, 32'h2,         1, 32'h4,         0, 32'h0);
    vt[11] = mk(0, 0, 0, 32'h0,         0, 4, 1,  1, 0, 1, 1, 3, 32'h3,         1, 32'h4,         0, 32'h0);
    vt[12] = mk(0, 0, 0, 32'h0,         0, 4, 1,  0, 0, 1, 1, 4, 32'h4,         1, 32'h4,         0, 32'h0);
    vt[13] = mk(0, 0, 0, 32'h0,         0, 4, 1,  0, 0, 1, 0, 4, 32'h4,         0, 32'h0,         0, 32'h0);
    vt[14] = mk(1, 0, 0, 32'h0,         0, 0, 0,  0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vt[15] = mk(0, 1, 0, 32'h55,        0, 0, 0,  0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vt[16] = mk(0, 0, 0, 32'h0,         0, 0, 0,  0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vt[17] = mk(0, 1, 7, 32'h11,        1, 7, 8,  1, 0, 0, 0, 0, 32'h0,         1, 32'h11,        0, 32'h0);
    vt[18] = mk(0, 1, 7, 32'h22,        1, 7, 8,  2, 0, 0, 0, 0, 32'h0,         1, 32'h22,        0, 32'h0);
    vt[19] = mk(0, 0, 0, 32'h0,         1, 7, 8,  2, 0, 0, 0, 0, 32'h0,         1, 32'h22,        0, 32'h0);
    vt[20] = mk(0, 1, 9, 32'h33,        1, 7, 9,  3, 0, 0, 0, 0, 32'h0,         1, 32'h22,        1, 32'h33);
    vt[21] = mk(1, 1, 10, 32'h44,       0, 7, 9,  0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vt[22] = mk(0, 0, 0, 32'h0,         0, 7, 9,  0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);

    // Directed vectors with hand-computed expectations
    for (int i = 0; i < 23; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(vt[i].rst, vt[i].push, vt[i].pa, vt[i].pd, vt[i].hold, vt[i].r1, vt[i].r2);
      chk({t, ".count"},    32'(bif.count),    32'(vt[i].cnt));
      chk({t, ".full"},     32'(bif.full),     32'(vt[i].full));
      chk({t, ".overflow"}, 32'(bif.overflow), 32'(vt[i].ovf));
      chk({t, ".wb_write"}, 32'(bif.wb_write), 32'(vt[i].wbw));
      chk({t, ".wb_addr"},  32'(bif.wb_addr),  32'(vt[i].wba));
      chk({t, ".wb_data"},  bif.wb_data,       vt[i].wbd);
      chk({t, ".hit1"},     32'(bif.hit1),     32'(vt[i].h1));
      chk({t, ".fwd1"},     bif.fwd1,          vt[i].f1);
      chk({t, ".hit2"},     32'(bif.hit2),     32'(vt[i].h2));
      chk({t, ".fwd2"},     bif.fwd2,          vt[i].f2);
    end

    // Streaming: push x1..x31 back to back, writes must come out in order
    issued = 0;
    next_expected = 1;
    for (int k = 1; k <= 33; k++) begin
      if (k <= 31)
        apply(1'b0, 1'b1, 5'(k), 32'h1000 * 32'(k) + 32'(k), 1'b0, 5'(k), 5'(k - 1));
      else
        apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 5'd30);
      chk("stream.count_le1", 32'(bif.count <= 1), 32'd1);
      chk("stream.no_ovf",    32'(bif.overflow),   32'd0);
      if (bif.wb_write) begin
        chk("stream.order", 32'(bif.wb_addr), 32'(next_expected));
        next_expected++;
        issued++;
      end
      check_model("stream");
    end
    chk("stream.issued", 32'(issued), 32'd31);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic r, p, h;
      r = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 9) < 7);
      h = ($urandom_range(0, 9) < 5);
      apply(r, p, 5'($urandom_range(0, 7)), $urandom, h,
            5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
